// File: rtl/trig_capture_pkg.sv
// rtl/trig_capture_pkg.sv - shared state and trigger-edge encodings for trig_capture
package trig_capture_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    PRE  = ST_PRE,
    WAIT = ST_WAIT,
    POST = ST_POST,
    DONE = ST_DONE
  } cap_state_t;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port capture RAM, registered read, array left unreset
module sdp_ram #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_in,
  input  logic                  RST_n,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; it holds its value between reads.
  always_ff @(posedge clk_in or negedge RST_n) begin
    if (!RST_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trig_capture.sv
// rtl/trig_capture.sv - level/edge trigger, circular pre/post window capture, oldest-first readout
module trig_capture
  import trig_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_in,
  input  logic                  RST_n,
  input  logic [DATA_WIDTH-1:0] CH_in,
  input  logic                  CH_valid,
  input  logic [DATA_WIDTH-1:0] Trig_level,
  input  logic                  Trig_edge,
  input  logic [DEPTH_LOG2-1:0] Pre_len,
  input  logic                  Arm,
  input  logic                  Force,
  input  logic                  Rd_en,
  output logic [DATA_WIDTH-1:0] Rd_data,
  output logic                  Rd_valid,
  output logic                  Busy,
  output logic                  Triggered,
  output logic                  Done
);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_LAST = '1;

  cap_state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] level_q, prev_q;
  logic                  edge_q, prev_vld, force_pend, trig_q, rd_valid_q;
  logic [DEPTH_LOG2-1:0] pre_len_q, wr_ptr, rd_ptr, pre_cnt, post_cnt;

  logic                  capturing, wr_fire, rd_fire, trig_fire;
  logic                  rise_hit, fall_hit, edge_hit, force_hit;
  logic [DEPTH_LOG2-1:0] pre_eff, post_init;

  assign capturing = (state == PRE) || (state == WAIT) || (state == POST);
  assign wr_fire   = CH_valid && capturing && !Arm;
  assign rd_fire   = Rd_en && (state == DONE) && !Arm;

  assign rise_hit  = (prev_q <  level_q) && (CH_in >= level_q);
  assign fall_hit  = (prev_q >= level_q) && (CH_in <  level_q);
  assign edge_hit  = prev_vld && (((edge_q == EDGE_RISE) && rise_hit) ||
                                  ((edge_q == EDGE_FALL) && fall_hit));
  assign force_hit = Force || force_pend;

  // A pending force turns the next valid sample of PRE or WAIT into the trigger.
  assign trig_fire = wr_fire && (((state == WAIT) && edge_hit) ||
                                 (((state == PRE) || (state == WAIT)) && force_hit));

  assign pre_eff   = (state == PRE) ? pre_cnt : pre_len_q;
  assign post_init = PTR_LAST - pre_len_q;

  always_ff @(posedge clk_in or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pre_len is DEPTH_LOG2 bits wide, so it can never exceed DEPTH-1.
  always_comb begin
    state_nxt = state;
    if (Arm) begin
      state_nxt = (Pre_len == '0) ? WAIT : PRE;
    end else if (trig_fire) begin
      state_nxt = (post_init == '0) ? DONE : POST;
    end else if (wr_fire) begin
      if ((state == PRE) && (pre_cnt + PTR_ONE == pre_len_q)) state_nxt = WAIT;
      if ((state == POST) && (post_cnt == PTR_ONE))           state_nxt = DONE;
    end
  end

  always_ff @(posedge clk_in or negedge RST_n) begin
    if (!RST_n) begin
      level_q    <= '0;
      edge_q     <= 1'b0;
      pre_len_q  <= '0;
      prev_q     <= '0;
      prev_vld   <= 1'b0;
      force_pend <= 1'b0;
      trig_q     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (Arm) begin
        level_q    <= Trig_level;
        edge_q     <= Trig_edge;
        pre_len_q  <= Pre_len;
        prev_vld   <= 1'b0;
        force_pend <= 1'b0;
        trig_q     <= 1'b0;
        wr_ptr     <= '0;
        pre_cnt    <= '0;
        post_cnt   <= '0;
      end else begin
        if (wr_fire) begin
          wr_ptr   <= wr_ptr + PTR_ONE;
          prev_q   <= CH_in;
          prev_vld <= 1'b1;
          if (state == PRE)  pre_cnt  <= pre_cnt + PTR_ONE;
          if (state == POST) post_cnt <= post_cnt - PTR_ONE;
        end
        if (trig_fire) begin
          trig_q     <= 1'b1;
          force_pend <= 1'b0;
          post_cnt   <= post_init;
          rd_ptr     <= wr_ptr - pre_eff;
        end else if (Force && ((state == PRE) || (state == WAIT))) begin
          force_pend <= 1'b1;
        end
        if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk_in  (clk_in),
    .RST_n   (RST_n),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr),
    .wr_data (CH_in),
    .rd_en   (rd_fire),
    .rd_addr (rd_ptr),
    .rd_data (Rd_data)
  );

  assign Rd_valid  = rd_valid_q;
  assign Busy      = capturing;
  assign Triggered = trig_q;
  assign Done      = (state == DONE);

endmodule
